blockade_boot_ctrl: RTL

Boot, reset and pause sequencer between the MiST `data_io` download port and the `blockade` game core. It forwards ROM bytes into the core's ROM write port, validates the download, holds the core in reset for a fixed stretch after a good load or a user reset, and aligns pause entry and exit to vertical blanking. It replaces the ad-hoc `rom_downloaded` latch and reset OR-gate in the top level.

---
 rtl/blockade_boot_pkg.sv | 15 +
 rtl/blockade_pause_sync.sv | 30 +++
 rtl/blockade_boot_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/blockade_boot_pkg.sv
// Shared types and widths for the blockade boot/reset/pause sequencer.
package blockade_boot_pkg;

    localparam int unsigned DN_ADDR_W  = 14;
    localparam int unsigned BYTE_CNT_W = DN_ADDR_W + 1;

    typedef enum logic [2:0] {
        NOROM,
        LOADING,
        CHECK,
        HOLD,
        RUN
    } boot_state_e;

endpackage

// File: rtl/blockade_pause_sync.sv
// Vertical-blank aligned pause register; pause is only held while the core runs.
module blockade_pause_sync (
    input  logic clk_sys,
    input  logic reset,
    input  logic run,
    input  logic pause_req,
    input  logic vblank,
    output logic pause
);

    logic vblank_q;
    logic vb_rise_c;

    assign vb_rise_c = vblank & ~vblank_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            vblank_q <= 1'b0;
            pause    <= 1'b0;
        end else begin
            vblank_q <= vblank;
            if (!run) begin
                pause <= 1'b0;
            end else if (vb_rise_c) begin
                pause <= pause_req;
            end
        end
    end

endmodule

// File: rtl/blockade_boot_ctrl.sv
// Boot sequencer: forwards ROM download bytes to the core, validates the load,
// stretches the core reset after a good load or user reset, and gates pause.
module blockade_boot_ctrl
    import blockade_boot_pkg::*;
#(
    parameter logic [7:0]  ROM_INDEX = 8'h00,
    parameter int unsigned ROM_SIZE  = 16384,
    parameter int unsigned MIN_BYTES = 1,
    parameter int unsigned RST_HOLD  = 1024
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  ioctl_downl,
    input  logic [7:0]            ioctl_index,
    input  logic                  ioctl_wr,
    input  logic [24:0]           ioctl_addr,
    input  logic [7:0]            ioctl_dout,
    input  logic                  user_reset,
    input  logic                  pause_req,
    input  logic                  vblank,
    output logic                  game_reset,
    output logic                  dn_wr,
    output logic [DN_ADDR_W-1:0]  dn_addr,
    output logic [7:0]            dn_data,
    output logic                  pause,
    output logic                  rom_valid,
    output logic                  load_err,
    output logic [BYTE_CNT_W-1:0] byte_cnt
);

    localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(RST_HOLD - 1);

    boot_state_e           state_q, state_d;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic                  nonzero_q, nonzero_d;
    logic                  rom_dl_q;
    logic                  rom_dl_c, dl_start_c, dl_end_c, in_range_c;
    logic                  game_reset_d, dn_wr_d, rom_valid_d, load_err_d;
    logic [DN_ADDR_W-1:0]  dn_addr_d;
    logic [7:0]            dn_data_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_d;

    assign rom_dl_c   = ioctl_downl && (ioctl_index == ROM_INDEX);
    assign dl_start_c = rom_dl_c && !rom_dl_q;
    assign dl_end_c   = !rom_dl_c && rom_dl_q;
    assign in_range_c = (ioctl_addr < 25'(ROM_SIZE));

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= NOROM;
            hold_cnt_q <= '0;
            nonzero_q  <= 1'b0;
            rom_dl_q   <= 1'b0;
            game_reset <= 1'b1;
            dn_wr      <= 1'b0;
            dn_addr    <= '0;
            dn_data    <= '0;
            rom_valid  <= 1'b0;
            load_err   <= 1'b0;
            byte_cnt   <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            nonzero_q  <= nonzero_d;
            rom_dl_q   <= rom_dl_c;
            game_reset <= game_reset_d;
            dn_wr      <= dn_wr_d;
            dn_addr    <= dn_addr_d;
            dn_data    <= dn_data_d;
            rom_valid  <= rom_valid_d;
            load_err   <= load_err_d;
            byte_cnt   <= byte_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        nonzero_d   = nonzero_q;
        dn_wr_d     = 1'b0;
        dn_addr_d   = dn_addr;
        dn_data_d   = dn_data;
        rom_valid_d = rom_valid;
        load_err_d  = load_err;
        byte_cnt_d  = byte_cnt;

        unique case (state_q)
            NOROM: begin
                if (dl_start_c) begin
                    state_d = LOADING;
                end
            end
            LOADING: begin
                // A write landing on the same cycle as the download end is kept.
                if (ioctl_wr && in_range_c) begin
                    dn_wr_d   = 1'b1;
                    dn_addr_d = ioctl_addr[DN_ADDR_W-1:0];
                    dn_data_d = ioctl_dout;
                    if (byte_cnt < BYTE_CNT_W'(ROM_SIZE)) begin
                        byte_cnt_d = byte_cnt + 1'b1;
                    end
                    if (ioctl_dout != 8'h00) begin
                        nonzero_d = 1'b1;
                    end
                end
                if (dl_end_c) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (nonzero_q && (byte_cnt >= BYTE_CNT_W'(MIN_BYTES))) begin
                    state_d     = HOLD;
                    hold_cnt_d  = HOLD_RELOAD;
                    rom_valid_d = 1'b1;
                end else begin
                    state_d    = NOROM;
                    load_err_d = 1'b1;
                end
            end
            HOLD: begin
                if (user_reset) begin
                    hold_cnt_d = HOLD_RELOAD;
                end else if (hold_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            RUN: begin
                if (dl_start_c) begin
                    state_d = LOADING;
                end else if (user_reset) begin
                    state_d    = HOLD;
                    hold_cnt_d = HOLD_RELOAD;
                end
            end
            default: begin
                state_d = NOROM;
            end
        endcase

        // Fresh download: forget everything about the previous one.
        if ((state_d == LOADING) && (state_q != LOADING)) begin
            byte_cnt_d  = '0;
            nonzero_d   = 1'b0;
            load_err_d  = 1'b0;
            rom_valid_d = 1'b0;
        end

        game_reset_d = (state_d != RUN);
    end

    blockade_pause_sync u_pause_sync (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .run       (state_d == RUN),
        .pause_req (pause_req),
        .vblank    (vblank),
        .pause     (pause)
    );

endmodule
